acc_drain_ctrl: RTL and testbench

- Read-side sequencer for the double-buffered accumulator memory.
- On a start command it issues a burst of accumulator reads, absorbs the accumulator's 1-cycle registered read latency, and streams the 64-bit results (col1 in [63:32], col0 in [31:0]) to the VPU/unified-buffer path over a valid/ready interface.
- Supports full-rate streaming under backpressure without dropping or duplicating words.

---
 rtl/tpu_acc_pkg.sv | 20 ++
 rtl/acc_skid_fifo.sv | 50 +++++
 rtl/acc_drain_ctrl.sv | 132 +++++++++++++
 tb/tb_acc_drain_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_acc_pkg.sv
// Shared accumulator-side types and sizes for the TPU datapath.
package tpu_acc_pkg;

  localparam int ACC_DATA_W = 64;
  localparam int ACC_ADDR_W = 8;
  localparam int ACC_DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } drain_state_t;

  typedef struct packed {
    logic [31:0] col1;
    logic [31:0] col0;
  } acc_word_t;

endpackage

// File: rtl/acc_skid_fifo.sv
// Small synchronous FIFO with flush and occupancy count; the head entry is
// presented combinationally.
module acc_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage carries no reset; validity is tracked purely by count_q.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/acc_drain_ctrl.sv
// Accumulator read sequencer: issues a read burst, absorbs the 1-cycle read
// latency and streams words out through a credit-managed skid FIFO.
module acc_drain_ctrl
  import tpu_acc_pkg::*;
#(
  parameter int DATA_W     = ACC_DATA_W,
  parameter int ADDR_W     = ACC_ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_base,
  input  logic [ADDR_W:0]   start_count,
  input  logic              start_buf_sel,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              acc_buf_sel,
  output logic              acc_rd_en,
  output logic [ADDR_W-1:0] acc_rd_addr,
  input  logic [DATA_W-1:0] acc_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  drain_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   left_q, left_d;
  logic              buf_sel_q, buf_sel_d;
  logic              inflight_q, inflight_last_q;

  logic              rd_en, rd_last, flush, pop, credit;
  logic [OCC_W-1:0]  occ;
  logic [DATA_W:0]   fifo_head;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign pop     = !fifo_empty && out_ready;
  assign occ     = OCC_W'(fifo_count) + OCC_W'(inflight_q);
  // A word popping this cycle frees its slot in time for the read issued now.
  assign credit  = (occ - OCC_W'(pop)) < OCC_W'(FIFO_DEPTH);
  assign rd_last = (left_q == (ADDR_W + 1)'(1));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    left_d    = left_q;
    buf_sel_d = buf_sel_q;
    rd_en     = 1'b0;
    flush     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = start_base;
          left_d    = start_count;
          buf_sel_d = start_buf_sel;
          state_d   = (start_count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = DONE;
        end else if (credit) begin
          rd_en  = 1'b1;
          addr_d = addr_q + 1'b1;
          left_d = left_q - 1'b1;
          if (rd_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = DONE;
        end else if (pop && fifo_head[DATA_W] && !inflight_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      left_q          <= '0;
      buf_sel_q       <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      left_q          <= left_d;
      buf_sel_q       <= buf_sel_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && rd_last;
    end
  end

  acc_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (inflight_q),
    .data_i  ({inflight_last_q, acc_rd_data}),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign acc_buf_sel = buf_sel_q;
  assign acc_rd_en   = rd_en;
  assign acc_rd_addr = addr_q;
  assign out_valid   = !fifo_empty;
  assign out_data    = fifo_head[DATA_W-1:0];
  assign out_last    = !fifo_empty && fifo_head[DATA_W];

endmodule

// File: tb/tb_acc_drain_ctrl.sv
// Directed bench for acc_drain_ctrl with an accumulator read model and a
// queue-based scoreboard for read addresses and streamed words.
module tb_acc_drain_ctrl;
  import tpu_acc_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, start_buf_sel, abort, out_ready;
  logic [7:0]  start_base;
  logic [8:0]  start_count;
  logic        busy, done, acc_buf_sel, acc_rd_en, out_valid, out_last;
  logic [7:0]  acc_rd_addr;
  logic [63:0] acc_rd_data, out_data;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_addr_q[$];
  logic [64:0] exp_word_q[$];
  logic        exp_buf;
  int          occ = 0;
  int          pops_total = 0;
  bit          mon_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [63:0] prev_data;

  always #5 clk = ~clk;

  acc_drain_ctrl #(.DATA_W(64), .ADDR_W(8), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .start_base(start_base),
    .start_count(start_count), .start_buf_sel(start_buf_sel), .abort(abort),
    .busy(busy), .done(done), .acc_buf_sel(acc_buf_sel), .acc_rd_en(acc_rd_en),
    .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  function automatic logic [63:0] acc_word(input logic b, input logic [7:0] a);
    acc_word_t w;
    w.col1 = {7'h55, b, 16'h0000, a};
    w.col0 = {24'hABCDEF, a};
    return w;
  endfunction

  // Accumulator: registered read, data valid the cycle after acc_rd_en.
  always @(posedge clk) begin
    if (acc_rd_en) acc_rd_data <= acc_word(acc_buf_sel, acc_rd_addr);
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
    return 1'b0;
  endfunction

  task automatic expect_burst(input logic [7:0] base, input logic [8:0] cnt, input logic b);
    exp_buf = b;
    for (int unsigned i = 0; i < cnt; i++) begin
      logic [7:0] a;
      a = 8'(base + i);
      exp_addr_q.push_back(a);
      exp_word_q.push_back({(i == cnt - 1), acc_word(b, a)});
    end
  endtask

  task automatic clear_sb();
    exp_addr_q.delete();
    exp_word_q.delete();
    occ = 0;
  endtask

  // Monitor: checks every read issue and every output handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      logic        pop_now;
      logic [7:0]  ea;
      logic [64:0] ew;
      pop_now = out_valid && out_ready;
      if (acc_rd_en) begin
        chk("rd_expected", exp_addr_q.size() != 0, 1'b1);
        if (exp_addr_q.size() != 0) begin
          ea = exp_addr_q.pop_front();
          chk("rd_addr", acc_rd_addr, ea);
        end
        chk("rd_buf_sel", acc_buf_sel, exp_buf);
        chk("rd_credit", (occ - int'(pop_now)) < 2, 1'b1);
      end
      if (out_valid && stall_prev) chk("stall_data", out_data, prev_data);
      if (pop_now) begin
        chk("word_expected", exp_word_q.size() != 0, 1'b1);
        if (exp_word_q.size() != 0) begin
          ew = exp_word_q.pop_front();
          chk("out_data", out_data, ew[63:0]);
          chk("out_last", out_last, ew[64]);
        end
        pops_total++;
      end
      occ = occ + int'(acc_rd_en) - int'(pop_now);
      stall_prev = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic run_burst(input logic [7:0] base, input logic [8:0] cnt, input logic b,
                           input int mode, input int limit, input int restart_cyc,
                           output int first_rd, output int first_ov,
                           output int last_cyc, output int done_cyc);
    @(posedge clk); #1;
    expect_burst(base, cnt, b);
    first_rd = -1; first_ov = -1; last_cyc = -1; done_cyc = -1;
    out_ready = ready_for(mode, 0);
    start = 1'b1; start_base = base; start_count = cnt; start_buf_sel = b;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      out_ready = ready_for(mode, cyc);
      start = (cyc == restart_cyc);
      if (start) begin
        start_base = 8'hAA; start_count = 9'd5; start_buf_sel = ~b;
      end
      @(negedge clk);
      if (acc_rd_en && first_rd < 0) first_rd = cyc;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && out_ready && out_last) last_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (done_cyc > 0) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      chk("idle_after_done", busy, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr, fo, lc, dc, p0;
    rst = 1'b1; start = 1'b0; start_base = '0; start_count = '0;
    start_buf_sel = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_en", acc_rd_en, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_addr", acc_rd_addr, 8'h00);
    chk("rst_buf", acc_buf_sel, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Basic burst: latency and completion timing.
    run_burst(8'h10, 9'd4, 1'b1, 0, 40, 0, fr, fo, lc, dc);
    chk("t1_first_rd", fr, 1);
    chk("t1_first_valid", fo, 3);
    chk("t1_last_hs", lc, 6);
    chk("t1_done", dc, 7);
    chk("t1_words_left", exp_word_q.size(), 0);

    // Backpressure pattern 1,0,0,1.
    run_burst(8'h40, 9'd8, 1'b0, 1, 100, 0, fr, fo, lc, dc);
    chk("t2_done_seen", dc > 0, 1'b1);
    chk("t2_words_left", exp_word_q.size(), 0);
    chk("t2_addr_left", exp_addr_q.size(), 0);

    // Address wrap.
    run_burst(8'hFC, 9'd8, 1'b1, 0, 40, 0, fr, fo, lc, dc);
    chk("t3_done", dc, 11);
    chk("t3_words_left", exp_word_q.size(), 0);

    // Full buffer at full rate.
    run_burst(8'h00, 9'd256, 1'b0, 0, 400, 0, fr, fo, lc, dc);
    chk("t4_last_hs", lc, 258);
    chk("t4_done", dc, 259);
    chk("t4_words_left", exp_word_q.size(), 0);

    // Zero-length burst.
    run_burst(8'h33, 9'd0, 1'b1, 0, 10, 0, fr, fo, lc, dc);
    chk("t5_done", dc, 1);
    chk("t5_no_rd", fr, -1);
    chk("t5_no_valid", fo, -1);

    // Start while busy is ignored.
    run_burst(8'h30, 9'd4, 1'b1, 0, 40, 2, fr, fo, lc, dc);
    chk("t6_done", dc, 7);
    chk("t6_words_left", exp_word_q.size(), 0);

    // Abort in IDLE has no effect.
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_busy", busy, 1'b0);
    chk("idle_abort_done", done, 1'b0);

    // Abort with 3 of 10 delivered and the stream stalled.
    @(posedge clk); #1;
    expect_burst(8'h20, 9'd10, 1'b0);
    p0 = pops_total;
    out_ready = 1'b1;
    start = 1'b1; start_base = 8'h20; start_count = 9'd10; start_buf_sel = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
      if (pops_total - p0 >= 3) begin
        out_ready = 1'b0;
        break;
      end
    end
    chk("t7_delivered", pops_total - p0, 3);
    repeat (3) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(negedge clk);
    chk("t7_full_valid", out_valid, 1'b1);
    chk("t7_abort_no_rd", acc_rd_en, 1'b0);
    @(posedge clk); #1;
    abort = 1'b0;
    clear_sb();
    @(negedge clk);
    chk("t7_flushed", out_valid, 1'b0);
    chk("t7_done", done, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t7_idle", busy, 1'b0);
    chk("t7_no_stale", out_valid, 1'b0);
    run_burst(8'h80, 9'd3, 1'b1, 0, 40, 0, fr, fo, lc, dc);
    chk("t7_next_done", dc, 6);
    chk("t7_next_words_left", exp_word_q.size(), 0);

    // Reset mid-burst.
    @(posedge clk); #1;
    expect_burst(8'h50, 9'd20, 1'b1);
    out_ready = 1'b1;
    start = 1'b1; start_base = 8'h50; start_count = 9'd20; start_buf_sel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_sb();
    @(negedge clk);
    chk("t8_busy", busy, 1'b0);
    chk("t8_done", done, 1'b0);
    chk("t8_rd_en", acc_rd_en, 1'b0);
    chk("t8_valid", out_valid, 1'b0);
    chk("t8_last", out_last, 1'b0);
    chk("t8_addr", acc_rd_addr, 8'h00);
    chk("t8_buf", acc_buf_sel, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("t8_no_done", done, 1'b0);
    end
    run_burst(8'h60, 9'd4, 1'b1, 0, 40, 0, fr, fo, lc, dc);
    chk("t8_next_done", dc, 7);
    chk("t8_next_words_left", exp_word_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
